// File: rtl/mod_det_3x3_serial.sv
// Stream-fed 3x3 signed determinant engine: loads nine elements row-major, then
// runs a nine-step cofactor expansion through one shared multiplier.
module mod_det_3x3_serial #(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] resultado,
    output logic         flag_overflow,
    output logic         busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned N_ELEM = 9;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ELEM - 1);

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_DONE} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt, step;
    logic [W-1:0]             elem [N_ELEM];
    logic signed [ACC_W-1:0]  m1, m2, m3, acc;
    logic [W-1:0]             op_a;
    logic signed [ACC_W-1:0]  op_b, prod, fin;
    logic                     accept, ovf;

    function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] x);
        return {{(ACC_W-W){x[W-1]}}, x};
    endfunction

    assign accept = in_ready & in_valid & ~clear;

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (accept && cnt == LAST) state_next = S_CALC;
                S_CALC:  if (step == LAST) state_next = S_DONE;
                S_DONE:  if (out_valid && out_ready) state_next = S_LOAD;
                default: state_next = S_LOAD;
            endcase
        end
    end

    // Operand steering for the shared multiplier.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (step)
            4'd0:    begin op_a = elem[4]; op_b = sext(elem[8]); end
            4'd1:    begin op_a = elem[5]; op_b = sext(elem[7]); end
            4'd2:    begin op_a = elem[3]; op_b = sext(elem[8]); end
            4'd3:    begin op_a = elem[5]; op_b = sext(elem[6]); end
            4'd4:    begin op_a = elem[3]; op_b = sext(elem[7]); end
            4'd5:    begin op_a = elem[4]; op_b = sext(elem[6]); end
            4'd6:    begin op_a = elem[0]; op_b = m1; end
            4'd7:    begin op_a = elem[1]; op_b = m2; end
            4'd8:    begin op_a = elem[2]; op_b = m3; end
            default: begin op_a = '0; op_b = '0; end
        endcase
    end

    assign prod = sext(op_a) * op_b;
    assign fin  = acc + prod;
    // Fits in W signed bits only if all bits from W-1 upward agree.
    assign ovf  = !((&fin[ACC_W-1:W-1]) || !(|fin[ACC_W-1:W-1]));

    always_ff @(posedge clk) begin
        if (accept) elem[cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_LOAD;
            cnt           <= '0;
            step          <= '0;
            m1            <= '0;
            m2            <= '0;
            m3            <= '0;
            acc           <= '0;
            resultado     <= '0;
            flag_overflow <= 1'b0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == S_LOAD);
            busy      <= (state_next == S_CALC);
            out_valid <= (state_next == S_DONE);
            if (clear) begin
                cnt           <= '0;
                step          <= '0;
                resultado     <= '0;
                flag_overflow <= 1'b0;
            end else begin
                if (accept) cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                if (state == S_CALC) begin
                    step <= (step == LAST) ? '0 : step + CNT_W'(1);
                    case (step)
                        4'd0:    m1 <= prod;
                        4'd1:    m1 <= m1 - prod;
                        4'd2:    m2 <= prod;
                        4'd3:    m2 <= m2 - prod;
                        4'd4:    m3 <= prod;
                        4'd5:    m3 <= m3 - prod;
                        4'd6:    acc <= prod;
                        4'd7:    acc <= acc - prod;
                        4'd8: begin
                            acc           <= fin;
                            resultado     <= fin[W-1:0];
                            flag_overflow <= ovf;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_det_3x3_serial.sv
// Directed bench for mod_det_3x3_serial: hand-computed determinants, latency,
// backpressure, clear and asynchronous reset behaviour.
module tb_mod_det_3x3_serial;

    logic       clk = 1'b0;
    logic       rst_n, clear, in_valid, in_ready, out_valid, out_ready, flag_overflow, busy;
    logic [7:0] in_data, resultado;
    int         checks = 0;
    int         errors = 0;

    localparam logic [71:0] IDENT  = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    localparam logic [71:0] SIGNED = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
    localparam logic [71:0] BIG    = {8'd127, 8'd0, 8'd0, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0, 8'd127};
    localparam logic [71:0] NEG1   = {8'hFF, 8'd0, 8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0, 8'hFF};
    localparam logic [71:0] MIXED  = {8'd3, 8'd1, 8'd2, 8'd0, 8'd4, 8'd1, 8'd2, 8'd0, 8'd5};
    localparam logic [71:0] MINUS  = {8'h80, 8'd0, 8'd0, 8'd0, 8'h80, 8'd0, 8'd0, 8'd0, 8'h80};

    always #5 clk = ~clk;

    mod_det_3x3_serial #(.W(8), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .resultado(resultado),
        .flag_overflow(flag_overflow), .busy(busy)
    );

    // Streams the first n elements; returns at the falling edge after the last accept.
    task automatic send(input logic [71:0] m, input bit gaps, input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 200) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = m[71-8*k -: 8];
                if (in_ready) k++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Counts falling edges until out_valid, bounded.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, busy, flag_overflow, resultado} !== {3'b100, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/vld/busy/ovf=%b%b%b%b res=%h, expected 1000 res=00",
                     in_ready, out_valid, busy, flag_overflow, resultado);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int cyc;
        send(IDENT, 1'b0, 9);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ident_calc_flags: got busy=%b in_ready=%b, expected busy=1 in_ready=0", busy, in_ready);
        end
        wait_result(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL ident_latency: got %0d cycles, expected 9", cyc);
        end
        checks++;
        if (resultado !== 8'h01 || flag_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ident_result: got %h ovf=%b, expected 01 ovf=0", resultado, flag_overflow);
        end
        handoff();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ident_handoff: got out_valid=%b in_ready=%b, expected 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_values(input logic [71:0] m, input bit gaps, input logic [7:0] exp_res,
                               input logic exp_ovf, input string name);
        int cyc;
        send(m, gaps, 9);
        wait_result(cyc);
        checks++;
        if (out_valid !== 1'b1 || resultado !== exp_res || flag_overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s: got vld=%b res=%h ovf=%b, expected vld=1 res=%h ovf=%b",
                     name, out_valid, resultado, flag_overflow, exp_res, exp_ovf);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        send(SIGNED, 1'b0, 9);
        wait_result(cyc);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || resultado !== 8'hFD || flag_overflow !== 1'b0) begin
                errors++;
                if (bad++ < 3)
                    $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b res=%h ovf=%b, expected 1 0 fd 0",
                             i, out_valid, in_ready, resultado, flag_overflow);
            end
            @(negedge clk);
        end
        handoff();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got out_valid=%b in_ready=%b, expected 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_clear();
        send(IDENT, 1'b0, 5);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || resultado !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got rdy=%b vld=%b res=%h busy=%b, expected 1 0 00 0",
                     in_ready, out_valid, resultado, busy);
        end
        test_values(IDENT, 1'b0, 8'h01, 1'b0, "clear_then_ident");
    endtask

    task automatic test_reset_mid_calc();
        send(SIGNED, 1'b0, 9);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midcalc_busy: got busy=%b out_valid=%b, expected 1 and 0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, flag_overflow, resultado} !== {3'b100, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midcalc_reset: got rdy/vld/busy/ovf=%b%b%b%b res=%h, expected 1000 res=00",
                     in_ready, out_valid, busy, flag_overflow, resultado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_values(MIXED, 1'b0, 8'h2E, 1'b0, "after_reset_mixed");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_values(SIGNED, 1'b0, 8'hFD, 1'b0, "signed_m3");
        test_values(BIG, 1'b0, 8'h7F, 1'b1, "overflow_pos");
        test_values(NEG1, 1'b0, 8'hFF, 1'b0, "diag_minus1");
        test_values(MINUS, 1'b0, 8'h00, 1'b1, "overflow_neg");
        test_values(MIXED, 1'b1, 8'h2E, 1'b0, "gapped_mixed");
        test_values(SIGNED, 1'b1, 8'hFD, 1'b0, "gapped_signed");
        test_backpressure();
        test_clear();
        test_values(NEG1, 1'b0, 8'hFF, 1'b0, "pre_reset_minus1");
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
